execute_stage: RTL and testbench

//  Y86-64 pipeline execute stage: selects ALU operands and function from the E-register fields and drives the 64-bit ALU.

---
 rtl/execute_stage.sv | 185 ++++++++++++++++++
 tb/tb_execute_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// Y86-64 pipeline execute stage. Picks ALU operands and function from the
// E-register fields, drives a W-bit ALU, and holds the condition codes
// {ZF,SF,OF}. It evaluates jXX/cmovXX conditions against the CC value that
// was current before this instruction, and registers the result into the
// M pipeline register.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   E_*                  fields of the E pipeline register
//   m_stat, W_stat       downstream status; an exception there blocks CC update
//   M_bubble             load a nop into the M register on this edge
//   e_valE/e_dstE/e_Cnd  combinational results, forwarded to decode
//   M_*                  M pipeline register outputs
//   cc                   current {ZF,SF,OF}
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM,
    output logic [2:0]   cc
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] S_AOK = 4'd1;
    localparam logic [3:0] S_HLT = 4'd2;
    localparam logic [3:0] S_ADR = 4'd3;
    localparam logic [3:0] S_INS = 4'd4;

    localparam logic [W-1:0] MINUS8 = ~W'(7);
    localparam logic [W-1:0] PLUS8  = W'(8);

    logic [W-1:0] alu_a, alu_b, alu_r;
    logic [1:0]   alu_fun;
    logic         alu_of;
    logic         set_cc;
    logic         lt;
    logic [2:0]   cc_d, cc_q;

    logic [3:0]   stat_q, icode_q, dste_q, dstm_q;
    logic         cnd_q;
    logic [W-1:0] vale_q, vala_q;

    always_comb begin
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = MINUS8;
            I_RET, I_POPQ:               alu_a = PLUS8;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:      alu_b = E_valB;
            default:                     alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == I_OPQ) ? E_ifun[1:0] : 2'b00;

    always_comb begin
        case (alu_fun)
            2'b00:   alu_r = alu_a + alu_b;
            2'b01:   alu_r = alu_b - alu_a;
            2'b10:   alu_r = alu_a & alu_b;
            default: alu_r = alu_a ^ alu_b;
        endcase
    end

    // Overflow from operand/result signs; logical ops never overflow.
    always_comb begin
        case (alu_fun)
            2'b00:   alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_r[W-1] != alu_a[W-1]);
            2'b01:   alu_of = (alu_b[W-1] != alu_a[W-1]) && (alu_r[W-1] != alu_b[W-1]);
            default: alu_of = 1'b0;
        endcase
    end

    // An exception already downstream must not let a younger OPQ alter CC.
    assign set_cc = (E_icode == I_OPQ)
                 && !(m_stat == S_HLT || m_stat == S_ADR || m_stat == S_INS)
                 && !(W_stat == S_HLT || W_stat == S_ADR || W_stat == S_INS);

    assign cc_d = {(alu_r == '0), alu_r[W-1], alu_of};

    // Conditions use the CC before this instruction's own update.
    assign lt = cc_q[1] ^ cc_q[0];

    always_comb begin
        case (E_ifun)
            4'h0:    e_Cnd = 1'b1;
            4'h1:    e_Cnd = lt | cc_q[2];
            4'h2:    e_Cnd = lt;
            4'h3:    e_Cnd = cc_q[2];
            4'h4:    e_Cnd = ~cc_q[2];
            4'h5:    e_Cnd = ~lt;
            4'h6:    e_Cnd = ~lt & ~cc_q[2];
            default: e_Cnd = 1'b0;
        endcase
    end

    assign e_valE = alu_r;
    assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q    <= 3'b100;
            stat_q  <= S_AOK;
            icode_q <= I_NOP;
            cnd_q   <= 1'b0;
            vale_q  <= '0;
            vala_q  <= '0;
            dste_q  <= RNONE;
            dstm_q  <= RNONE;
        end else begin
            if (set_cc) begin
                cc_q <= cc_d;
            end
            if (M_bubble) begin
                stat_q  <= S_AOK;
                icode_q <= I_NOP;
                cnd_q   <= 1'b0;
                vale_q  <= '0;
                vala_q  <= '0;
                dste_q  <= RNONE;
                dstm_q  <= RNONE;
            end else begin
                stat_q  <= E_stat;
                icode_q <= E_icode;
                cnd_q   <= e_Cnd;
                vale_q  <= alu_r;
                vala_q  <= E_valA;
                dste_q  <= e_dstE;
                dstm_q  <= E_dstM;
            end
        end
    end

    assign cc      = cc_q;
    assign M_stat  = stat_q;
    assign M_icode = icode_q;
    assign M_Cnd   = cnd_q;
    assign M_valE  = vale_q;
    assign M_valA  = vala_q;
    assign M_dstE  = dste_q;
    assign M_dstM  = dstm_q;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
// Directed and random stimulus for execute_stage, checked against an
// instruction-level reference model of the Y86-64 execute rules.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
    logic [2:0]  cc;

    int checks   = 0;
    int failures = 0;

    logic [2:0]  cc_m;
    logic [63:0] exp_valE;
    logic [3:0]  exp_dstE;
    logic        exp_cnd;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .cc(cc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what the instruction should produce, from the ISA rules.
    function automatic logic cond_of(input logic [3:0] fn, input logic [2:0] f);
        logic z, s, o;
        {z, s, o} = f;
        case (fn)
            0: return 1'b1;            // always
            1: return (s != o) || z;   // le
            2: return (s != o);        // l
            3: return z;               // e
            4: return !z;              // ne
            5: return (s == o);        // ge
            6: return (s == o) && !z;  // g
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic inhibit(input logic [3:0] s);
        return (s >= 2 && s <= 4);
    endfunction

    task automatic model(output logic [63:0] r, output logic [2:0] newcc);
        logic [63:0] a, b;
        logic [64:0] wide;
        logic        ovf;
        a = 0; b = 0; ovf = 0;
        if (E_icode == 2 || E_icode == 6)                      a = E_valA;
        else if (E_icode >= 3 && E_icode <= 5)                 a = E_valC;
        else if (E_icode == 8 || E_icode == 10)                a = -64'sd8;
        else if (E_icode == 9 || E_icode == 11)                a = 64'd8;
        if ((E_icode >= 4 && E_icode <= 6) || (E_icode >= 8 && E_icode <= 11)) b = E_valB;
        if (E_icode == 6 && E_ifun[1:0] == 1) begin
            wide = {b[63], b} - {a[63], a};
            r = wide[63:0];
            ovf = (wide[64] != wide[63]);
        end else if (E_icode == 6 && E_ifun[1:0] == 2) begin
            r = a & b;
        end else if (E_icode == 6 && E_ifun[1:0] == 3) begin
            r = a ^ b;
        end else begin
            wide = {a[63], a} + {b[63], b};
            r = wide[63:0];
            ovf = (wide[64] != wide[63]);
        end
        newcc = {r == 64'd0, r[63], ovf};
    endtask

    task automatic step(input string tag, input logic r_in, input logic [3:0] st,
                        input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [3:0] ms, input logic [3:0] ws, input logic bub);
        logic [63:0] r;
        logic [2:0]  ncc;
        rst = r_in; E_stat = st; E_icode = ic; E_ifun = fn; E_valC = vc;
        E_valA = va; E_valB = vb; E_dstE = de; E_dstM = dm;
        m_stat = ms; W_stat = ws; M_bubble = bub;
        model(r, ncc);
        exp_valE = r;
        exp_cnd  = cond_of(fn, cc_m);
        exp_dstE = (ic == 2 && !exp_cnd) ? 4'hF : de;
        #1;
        chk({tag, ".e_valE"}, e_valE, exp_valE);
        chk({tag, ".e_Cnd"},  {63'd0, e_Cnd}, {63'd0, exp_cnd});
        chk({tag, ".e_dstE"}, {60'd0, e_dstE}, {60'd0, exp_dstE});
        @(posedge clk);
        #1;
        if (r_in) cc_m = 3'b100;
        else if (ic == 6 && !inhibit(ms) && !inhibit(ws)) cc_m = ncc;
        chk({tag, ".cc"}, {61'd0, cc}, {61'd0, cc_m});
        if (r_in || bub) begin
            chk({tag, ".M_nop"}, {M_stat, M_icode, 3'd0, M_Cnd, M_dstE, M_dstM, M_valE[47:0]},
                {4'd1, 4'd1, 3'd0, 1'b0, 4'hF, 4'hF, 48'd0});
            chk({tag, ".M_valAE"}, M_valA | M_valE, 64'd0);
        end else begin
            chk({tag, ".M_ctl"}, {44'd0, M_stat, M_icode, 3'd0, M_Cnd, M_dstE, M_dstM},
                {44'd0, st, ic, 3'd0, exp_cnd, exp_dstE, dm});
            chk({tag, ".M_valE"}, M_valE, exp_valE);
            chk({tag, ".M_valA"}, M_valA, va);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    initial begin
        cc_m = 3'b000;
        rst = 1'b1; E_stat = 1; E_icode = 1; E_ifun = 0; E_valC = 0; E_valA = 0;
        E_valB = 0; E_dstE = 4'hF; E_dstM = 4'hF; m_stat = 1; W_stat = 1; M_bubble = 0;
        @(posedge clk); #1;
        cc_m = 3'b100;
        chk("reset.M_icode", {60'd0, M_icode}, 64'd1);
        chk("reset.M_dstE",  {60'd0, M_dstE}, 64'hF);
        chk("reset.M_valE",  M_valE, 64'd0);
        chk("reset.cc",      {61'd0, cc}, 64'd4);

        // signed overflow on add
        step("add_ovf", 0, 1, 6, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd2, 4'hF, 1, 1, 0);
        chk("add_ovf.M_valE", M_valE, 64'h8000_0000_0000_0000);
        chk("add_ovf.cc", {61'd0, cc}, 64'b011);

        // equal compare then je/jne
        step("sub_eq", 0, 1, 6, 1, 0, 64'd5, 64'd5, 4'd2, 4'hF, 1, 1, 0);
        chk("sub_eq.cc", {61'd0, cc}, 64'b100);
        step("je", 0, 1, 7, 3, 64'h40, 0, 0, 4'hF, 4'hF, 1, 1, 0);
        chk("je.Cnd", {63'd0, M_Cnd}, 64'd1);
        step("jne", 0, 1, 7, 4, 64'h40, 0, 0, 4'hF, 4'hF, 1, 1, 0);
        chk("jne.Cnd", {63'd0, M_Cnd}, 64'd0);

        // cmovl not taken (cc=000), then taken (cc=010)
        step("set000", 0, 1, 6, 0, 0, 64'd1, 64'd1, 4'd4, 4'hF, 1, 1, 0);
        chk("set000.cc", {61'd0, cc}, 64'b000);
        step("cmovl_nt", 0, 1, 2, 2, 0, 64'd9, 0, 4'd3, 4'hF, 1, 1, 0);
        chk("cmovl_nt.M_dstE", {60'd0, M_dstE}, 64'hF);
        step("set010", 0, 1, 6, 1, 0, 64'd5, 64'd3, 4'd4, 4'hF, 1, 1, 0);
        chk("set010.cc", {61'd0, cc}, 64'b010);
        step("cmovl_t", 0, 1, 2, 2, 0, 64'd9, 0, 4'd3, 4'hF, 1, 1, 0);
        chk("cmovl_t.M_dstE", {60'd0, M_dstE}, 64'd3);
        chk("cmovl_t.M_valE", M_valE, 64'd9);

        // downstream exceptions inhibit CC
        step("xor_m", 0, 1, 6, 3, 0, 64'hAA, 64'hAA, 4'd5, 4'hF, 3, 1, 0);
        chk("xor_m.M_valE", M_valE, 64'd0);
        chk("xor_m.cc", {61'd0, cc}, 64'b010);
        step("xor_w", 0, 1, 6, 3, 0, 64'hAA, 64'hAA, 4'd5, 4'hF, 1, 2, 0);
        chk("xor_w.cc", {61'd0, cc}, 64'b010);

        // bubble into M while pushq computes
        step("push_bub", 0, 1, 10, 0, 0, 64'd0, 64'h100, 4'd4, 4'hF, 1, 1, 1);
        chk("push_bub.cc", {61'd0, cc}, 64'b010);

        // bubble does not cancel CC update; reset overrides everything
        step("opq_bub", 0, 1, 6, 2, 0, 64'hF0, 64'h0F, 4'd1, 4'hF, 1, 1, 1);
        chk("opq_bub.cc", {61'd0, cc}, 64'b100);
        step("rst_opq", 1, 1, 6, 0, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             4'd1, 4'hF, 1, 1, 1);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] ic, fn, ms, ws;
            ic = 4'($urandom_range(0, 11));
            fn = (ic == 6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            ms = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            ws = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            step("rnd", ($urandom_range(0, 49) == 0), 4'($urandom_range(1, 4)), ic, fn,
                 rnd64(), rnd64(), rnd64(), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), ms, ws, ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
